// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU-sharing arbiter:
//   - ALU operation codes understood by the attached ALU
//   - FSM state encoding used by alu_share_arb
//   - requester identifiers (A=0, B=1) used for grant/owner bookkeeping
// No ports; imported by rr_arb2 and alu_share_arb.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_SEL_W  = 4;

  // ALU operation codes. Codes 6..15 are undefined; the ALU answers them
  // with result=0/zero=1 and this block forwards that unchanged.
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'd5;

  // Arbiter FSM states.
  //   ST_IDLE : waiting for a request, the only state that accepts one
  //   ST_EXEC : operands are on the ALU inputs, result settles this cycle
  //   ST_RESP : captured result offered to the owning requester
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Requester identifiers.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Bundle of the FSM-visible state, convenient for attaching checkers.
  typedef struct packed {
    state_t  state;
    req_id_t owner;
    req_id_t last_grant;
  } arb_dbg_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_a, req_b : request lines from requester A and B
//   last_grant   : requester that was served most recently (0=A, 1=B)
//   grant        : one-hot grant, bit 0 = A, bit 1 = B; all zero when idle
// With a single request, that requester wins. With both requesting, the one
// that was not served last wins, so neither side can starve the other.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_a && req_b) begin
      grant = (last_grant == REQ_B) ? 2'b01 : 2'b10;
    end else if (req_a) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb
// Shares one combinational ALU between two requesters (A and B).
// Each requester has a valid/ready request channel (in1, in2, sel) and a
// valid/ready response channel (result, zero). The block arbitrates
// round-robin, registers the winner's operands onto the ALU inputs, captures
// the ALU's result/zero one cycle later and offers them to the winner.
//
// Handshake rule (both channels, both requesters): a transfer happens on a
// rising clk edge where valid and ready are both 1. The sender keeps valid
// and its payload stable until that edge; it may drop valid earlier, which
// simply withdraws the request. Ready never depends on the payload.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_a_valid/ready/in1/in2/sel   request channel A
//   rsp_a_valid/ready/result/zero   response channel A
//   req_b_* / rsp_b_*               same for requester B
//   alu_in1, alu_in2, alu_sel       registered operands driven into the ALU
//   alu_result, alu_zero            combinational ALU outputs
//
// Timing: accept on edge N, EXEC during the next cycle, response valid from
// the cycle after that. With the response consumed immediately, accepts are
// at least 3 cycles apart.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic [DATA_W-1:0] req_a_in1,
  input  logic [DATA_W-1:0] req_a_in2,
  input  logic [SEL_W-1:0]  req_a_sel,
  output logic              rsp_a_valid,
  input  logic              rsp_a_ready,
  output logic [DATA_W-1:0] rsp_a_result,
  output logic              rsp_a_zero,

  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic [DATA_W-1:0] req_b_in1,
  input  logic [DATA_W-1:0] req_b_in2,
  input  logic [SEL_W-1:0]  req_b_sel,
  output logic              rsp_b_valid,
  input  logic              rsp_b_ready,
  output logic [DATA_W-1:0] rsp_b_result,
  output logic              rsp_b_zero,

  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  req_id_t           owner;       // requester whose operation is in flight
  req_id_t           last_grant;  // requester served most recently
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;

  // Debug view of the control state, for attaching checkers.
  arb_dbg_t          dbg;
  assign dbg = '{state: state, owner: owner, last_grant: last_grant};

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [1:0] grant;
  logic       accept_a;
  logic       accept_b;
  logic       rsp_fire;

  rr_arb2 u_rr_arb2 (
    .req_a      (req_a_valid),
    .req_b      (req_b_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept_a = req_a_valid && req_a_ready;
  assign accept_b = req_b_valid && req_b_ready;

  // Response consumed by whichever requester owns the current operation.
  assign rsp_fire = (owner == REQ_A) ? rsp_a_ready : rsp_b_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_a || accept_b) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // Gated by rst_n so nothing handshakes while reset is being applied,
  // even before the reset edge has cleared the state register.
  // ---------------------------------------------------------------------
  always_comb begin
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    rsp_a_valid = 1'b0;
    rsp_b_valid = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          req_a_ready = grant[0];
          req_b_ready = grant[1];
        end
        ST_RESP: begin
          rsp_a_valid = (owner == REQ_A);
          rsp_b_valid = (owner == REQ_B);
        end
        default: begin
        end
      endcase
    end
  end

  // Both response channels show the same captured value; valid tells the
  // owner apart.
  assign rsp_a_result = rsp_result_q;
  assign rsp_a_zero   = rsp_zero_q;
  assign rsp_b_result = rsp_result_q;
  assign rsp_b_zero   = rsp_zero_q;

  // ---------------------------------------------------------------------
  // Operand, response and bookkeeping registers
  // The ALU operand registers keep their last value after an operation;
  // they only change on the next accept.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_sel      <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      owner        <= REQ_A;
      last_grant   <= REQ_B;
    end else begin
      if (accept_a) begin
        alu_in1 <= req_a_in1;
        alu_in2 <= req_a_in2;
        alu_sel <= req_a_sel;
        owner   <= REQ_A;
      end else if (accept_b) begin
        alu_in1 <= req_b_in1;
        alu_in2 <= req_b_in2;
        alu_sel <= req_b_sel;
        owner   <= REQ_B;
      end

      // Operands have been stable on the ALU for the whole EXEC cycle.
      if (state == ST_EXEC) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
      end

      // Fairness is updated only once the owner has taken its response.
      if ((state == ST_RESP) && rsp_fire) begin
        last_grant <= owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
// Self-checking bench for alu_share_arb. A behavioural ALU drives the DUT's
// ALU inputs. A cycle monitor keeps an abstract model (busy flag, cycles
// since accept, who was served last) and checks readies, valids, operands
// and results every cycle; scenario tasks add directed checks.
module tb_alu_share_arb;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a_valid, req_a_ready, rsp_a_valid, rsp_a_ready, rsp_a_zero;
  logic [DW-1:0] req_a_in1, req_a_in2, rsp_a_result;
  logic [SW-1:0] req_a_sel;
  logic          req_b_valid, req_b_ready, rsp_b_valid, rsp_b_ready, rsp_b_zero;
  logic [DW-1:0] req_b_in1, req_b_in2, rsp_b_result;
  logic [SW-1:0] req_b_sel;
  logic [DW-1:0] alu_in1, alu_in2, alu_result;
  logic [SW-1:0] alu_sel;
  logic          alu_zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- behavioural ALU ----------------
  function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    case (s)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  assign {alu_zero, alu_result} = ref_alu(alu_in1, alu_in2, alu_sel);

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_in1(req_a_in1), .req_a_in2(req_a_in2), .req_a_sel(req_a_sel),
    .rsp_a_valid(rsp_a_valid), .rsp_a_ready(rsp_a_ready),
    .rsp_a_result(rsp_a_result), .rsp_a_zero(rsp_a_zero),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
    .req_b_in1(req_b_in1), .req_b_in2(req_b_in2), .req_b_sel(req_b_sel),
    .rsp_b_valid(rsp_b_valid), .rsp_b_ready(rsp_b_ready),
    .rsp_b_result(rsp_b_result), .rsp_b_zero(rsp_b_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // ---------------- reference model / monitor ----------------
  bit            mon_en = 0;
  bit            m_busy = 0;
  int            m_age  = 0;   // clock edges since the accept edge
  bit            m_last = 1;   // 1 = B served last
  bit            m_owner = 0;
  logic [DW-1:0] m_in1, m_in2, m_res;
  logic [SW-1:0] m_sel;
  logic          m_zero;

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ra, exp_rb, exp_va, exp_vb;
      if (m_busy) m_age++;
      if (!rst_n) begin
        exp_ra = 0; exp_rb = 0; exp_va = 0; exp_vb = 0;
      end else begin
        exp_ra = !m_busy && req_a_valid && (!req_b_valid || m_last);
        exp_rb = !m_busy && req_b_valid && (!req_a_valid || !m_last);
        exp_va = m_busy && (m_age >= 2) && !m_owner;
        exp_vb = m_busy && (m_age >= 2) && m_owner;
      end
      n_cmp += 4;
      if (req_a_ready !== exp_ra) begin
        n_err++; $display("FAIL mon_req_a_ready cyc=%0d got=%b exp=%b", cyc, req_a_ready, exp_ra);
      end
      if (req_b_ready !== exp_rb) begin
        n_err++; $display("FAIL mon_req_b_ready cyc=%0d got=%b exp=%b", cyc, req_b_ready, exp_rb);
      end
      if (rsp_a_valid !== exp_va) begin
        n_err++; $display("FAIL mon_rsp_a_valid cyc=%0d got=%b exp=%b", cyc, rsp_a_valid, exp_va);
      end
      if (rsp_b_valid !== exp_vb) begin
        n_err++; $display("FAIL mon_rsp_b_valid cyc=%0d got=%b exp=%b", cyc, rsp_b_valid, exp_vb);
      end
      if (exp_va || exp_vb) begin
        logic [DW-1:0] gr;
        logic          gz;
        gr = exp_va ? rsp_a_result : rsp_b_result;
        gz = exp_va ? rsp_a_zero : rsp_b_zero;
        n_cmp++;
        if (gr !== m_res || gz !== m_zero) begin
          n_err++;
          $display("FAIL mon_rsp_data cyc=%0d got=%h/%b exp=%h/%b", cyc, gr, gz, m_res, m_zero);
        end
      end
      if (rst_n && m_busy && m_age >= 1) begin
        n_cmp++;
        if (alu_in1 !== m_in1 || alu_in2 !== m_in2 || alu_sel !== m_sel) begin
          n_err++;
          $display("FAIL mon_alu_ops cyc=%0d got=%h,%h,%h exp=%h,%h,%h", cyc,
                   alu_in1, alu_in2, alu_sel, m_in1, m_in2, m_sel);
        end
      end
      // advance model to what the coming edge does
      if (!rst_n) begin
        m_busy = 0; m_last = 1;
      end else if (m_busy && m_age >= 2 && (m_owner ? rsp_b_ready : rsp_a_ready)) begin
        m_busy = 0; m_last = m_owner;
      end else if (exp_ra || exp_rb) begin
        m_busy = 1; m_age = 0; m_owner = exp_rb;
        m_in1 = exp_rb ? req_b_in1 : req_a_in1;
        m_in2 = exp_rb ? req_b_in2 : req_a_in2;
        m_sel = exp_rb ? req_b_sel : req_a_sel;
        {m_zero, m_res} = ref_alu(m_in1, m_in2, m_sel);
      end
    end
  end

  // ---------------- driver task ----------------
  // Issue one request on port p (0=A, 1=B), wait for accept and response.
  task automatic do_op(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [SW-1:0] s, input bit ack,
                       output logic [DW-1:0] res, output logic z, output int acc, output int lat);
    bit ok;
    res = '0; z = 1'b0; acc = -1; lat = -1; ok = 0;
    if (p == 0) begin
      req_a_valid = 1; req_a_in1 = a; req_a_in2 = b; req_a_sel = s;
      if (ack) rsp_a_ready = 1;
    end else begin
      req_b_valid = 1; req_b_in1 = a; req_b_in2 = b; req_b_sel = s;
      if (ack) rsp_b_ready = 1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? req_a_ready : req_b_ready) begin ok = 1; acc = cyc; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL do_op_accept port=%0d got=no_ready exp=ready", p); end
    @(posedge clk); #1;
    if (p == 0) req_a_valid = 0; else req_b_valid = 0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if ((p == 0) ? rsp_a_valid : rsp_b_valid) begin
          ok = 1; lat = cyc - acc;
          res = (p == 0) ? rsp_a_result : rsp_b_result;
          z   = (p == 0) ? rsp_a_zero : rsp_b_zero;
          break;
        end
        @(posedge clk); #1;
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL do_op_rsp port=%0d got=no_valid exp=valid", p); end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 req_a_valid = 1; req_b_valid = 1;
    @(negedge clk);
    n_cmp += 3;
    if ({req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid} !== 4'b0) begin
      n_err++; $display("FAIL reset_handshake got=%b exp=0000",
                        {req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid});
    end
    if (alu_in1 !== 0 || alu_in2 !== 0 || alu_sel !== 0) begin
      n_err++; $display("FAIL reset_alu_regs got=%h,%h,%h exp=0,0,0", alu_in1, alu_in2, alu_sel);
    end
    if (rsp_a_result !== 0 || rsp_a_zero !== 0) begin
      n_err++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_a_result, rsp_a_zero);
    end
    mon_en = 1;
    @(posedge clk); #1;
    req_a_valid = 0; req_b_valid = 0; rst_n = 1;
  endtask

  task automatic test_a_only();
    req_a_valid = 1; req_a_in1 = 5; req_a_in2 = 7; req_a_sel = 0; rsp_a_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (req_a_ready !== 1 || req_b_ready !== 0) begin
      n_err++; $display("FAIL a_only_ready got=%b%b exp=10", req_a_ready, req_b_ready);
    end
    @(posedge clk); #1 req_a_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (alu_in1 !== 5 || alu_in2 !== 7 || rsp_a_valid !== 0) begin
      n_err++; $display("FAIL a_only_exec got=%0d,%0d,v%b exp=5,7,v0", alu_in1, alu_in2, rsp_a_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (rsp_a_valid !== 1 || rsp_a_result !== 12 || rsp_a_zero !== 0 || rsp_b_valid !== 0) begin
      n_err++; $display("FAIL a_only_rsp got=v%b %0d/%b bv%b exp=v1 12/0 bv0",
                        rsp_a_valid, rsp_a_result, rsp_a_zero, rsp_b_valid);
    end
    @(posedge clk); #1 rsp_a_ready = 1;
    @(posedge clk); #1 rsp_a_ready = 0;
  endtask

  task automatic test_contention();
    int order[$];
    logic [DW-1:0] ra, rb;
    logic za, zb;
    bit got_a, got_b;
    got_a = 0; got_b = 0; ra = 'x; rb = 'x; za = 'x; zb = 'x;
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    req_a_valid = 1; req_a_in1 = 10;    req_a_in2 = 10;    req_a_sel = 1;
    req_b_valid = 1; req_b_in1 = 32'hF0; req_b_in2 = 32'h0F; req_b_sel = 2;
    rsp_a_ready = 1; rsp_b_ready = 1;
    for (int i = 0; i < 30 && order.size() < 3; i++) begin
      @(negedge clk);
      if (req_a_ready) order.push_back(0);
      if (req_b_ready) order.push_back(1);
      if (rsp_a_valid && !got_a) begin got_a = 1; ra = rsp_a_result; za = rsp_a_zero; end
      if (rsp_b_valid && !got_b) begin got_b = 1; rb = rsp_b_result; zb = rsp_b_zero; end
      @(posedge clk); #1;
    end
    req_a_valid = 0; req_b_valid = 0;
    n_cmp++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      n_err++; $display("FAIL contention_order got=%p exp='{0,1,0}", order);
    end
    n_cmp++;
    if (ra !== 0 || za !== 1) begin
      n_err++; $display("FAIL contention_a_rsp got=%h/%b exp=0/1", ra, za);
    end
    n_cmp++;
    if (rb !== 0 || zb !== 1) begin
      n_err++; $display("FAIL contention_b_rsp got=%h/%b exp=0/1", rb, zb);
    end
    repeat (4) @(posedge clk);
    #1 rsp_a_ready = 0; rsp_b_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] res[3];
    logic z[3];
    int acc[3], lat[3];
    logic [DW-1:0] exp_r[3];
    exp_r[0] = 3; exp_r[1] = 5; exp_r[2] = 1;
    do_op(1, 1, 2, 3, 1, res[0], z[0], acc[0], lat[0]);
    do_op(1, 6, 3, 4, 1, res[1], z[1], acc[1], lat[1]);
    do_op(1, 32'hFFFF_FFFF, 1, 5, 1, res[2], z[2], acc[2], lat[2]);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (res[i] !== exp_r[i] || z[i] !== 0 || lat[i] != 2) begin
        n_err++; $display("FAIL b2b_rsp%0d got=%0d/%b lat%0d exp=%0d/0 lat2",
                          i, res[i], z[i], lat[i], exp_r[i]);
      end
    end
    n_cmp++;
    if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      n_err++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc[1] - acc[0], acc[2] - acc[1]);
    end
    rsp_b_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, res, hold_r;
    logic [SW-1:0] s;
    logic z, hold_z, ez;
    logic [DW-1:0] er;
    int acc, lat;
    a = $urandom(); b = $urandom(); s = SW'($urandom_range(0, 5));
    {ez, er} = ref_alu(a, b, s);
    rsp_a_ready = 0;
    do_op(0, a, b, s, 0, res, z, acc, lat);
    n_cmp++;
    if (res !== er || z !== ez) begin
      n_err++; $display("FAIL bp_first_rsp got=%h/%b exp=%h/%b", res, z, er, ez);
    end
    hold_r = er; hold_z = ez;
    req_b_valid = 1; req_b_in1 = $urandom(); req_b_in2 = $urandom(); req_b_sel = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_a_valid !== 1 || rsp_a_result !== hold_r || rsp_a_zero !== hold_z || req_b_ready !== 0) begin
        n_err++; $display("FAIL bp_hold%0d got=v%b %h/%b rb%b exp=v1 %h/%b rb0",
                          i, rsp_a_valid, rsp_a_result, rsp_a_zero, req_b_ready, hold_r, hold_z);
      end
      @(posedge clk); #1;
    end
    rsp_a_ready = 1;
    @(posedge clk); #1 rsp_a_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (req_b_ready !== 1) begin
      n_err++; $display("FAIL bp_b_accept got=%b exp=1", req_b_ready);
    end
    @(posedge clk); #1 req_b_valid = 0; rsp_b_ready = 1;
    repeat (4) @(posedge clk);
    #1 rsp_b_ready = 0;
  endtask

  task automatic test_undefined_op();
    logic [DW-1:0] res;
    logic z;
    int acc, lat;
    do_op(0, 3, 4, 9, 1, res, z, acc, lat);
    n_cmp++;
    if (res !== 0 || z !== 1 || lat != 2) begin
      n_err++; $display("FAIL undef_op got=%h/%b lat%0d exp=0/1 lat2", res, z, lat);
    end
    rsp_a_ready = 0;
  endtask

  task automatic test_reset_mid_op();
    req_a_valid = 1; req_a_in1 = 32'h1234; req_a_in2 = 32'h55; req_a_sel = 0; rsp_a_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (req_a_ready !== 1) begin
      n_err++; $display("FAIL rmid_accept got=%b exp=1", req_a_ready);
    end
    @(posedge clk); #1 req_a_valid = 0; rst_n = 0;
    @(negedge clk);
    n_cmp++;
    if ({req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid} !== 4'b0) begin
      n_err++; $display("FAIL rmid_in_reset got=%b exp=0000",
                        {req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid});
    end
    @(posedge clk); #1 rst_n = 1;
    req_a_valid = 1; req_a_in1 = 2; req_a_in2 = 2; req_a_sel = 4;
    req_b_valid = 1; req_b_in1 = 9; req_b_in2 = 1; req_b_sel = 1; rsp_b_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (alu_in1 !== 0 || alu_in2 !== 0 || alu_sel !== 0 || rsp_a_result !== 0 || rsp_a_valid !== 0) begin
      n_err++; $display("FAIL rmid_cleared got=%h,%h,%h r%h v%b exp=0,0,0 r0 v0",
                        alu_in1, alu_in2, alu_sel, rsp_a_result, rsp_a_valid);
    end
    n_cmp++;
    if (req_a_ready !== 1 || req_b_ready !== 0) begin
      n_err++; $display("FAIL rmid_grant got=%b%b exp=10", req_a_ready, req_b_ready);
    end
    @(posedge clk); #1 req_a_valid = 0;
    repeat (8) @(posedge clk);
    #1 req_b_valid = 0;
    repeat (4) @(posedge clk);
    #1 rsp_a_ready = 0; rsp_b_ready = 0;
  endtask

  task automatic test_random();
    bit hs_a, hs_b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      hs_a = req_a_valid && req_a_ready;
      hs_b = req_b_valid && req_b_ready;
      @(posedge clk); #1;
      if (hs_a || (req_a_valid && $urandom_range(0, 15) == 0)) begin
        req_a_valid = 0;
      end else if (!req_a_valid && $urandom_range(0, 1) == 1) begin
        req_a_valid = 1; req_a_in1 = $urandom(); req_a_sel = SW'($urandom_range(0, 7));
        req_a_in2 = ($urandom_range(0, 3) == 0) ? req_a_in1 : $urandom();
      end
      if (hs_b || (req_b_valid && $urandom_range(0, 15) == 0)) begin
        req_b_valid = 0;
      end else if (!req_b_valid && $urandom_range(0, 1) == 1) begin
        req_b_valid = 1; req_b_in1 = $urandom(); req_b_sel = SW'($urandom_range(0, 7));
        req_b_in2 = ($urandom_range(0, 3) == 0) ? req_b_in1 : $urandom();
      end
      rsp_a_ready = ($urandom_range(0, 1) == 1);
      rsp_b_ready = ($urandom_range(0, 1) == 1);
    end
    req_a_valid = 0; req_b_valid = 0; rsp_a_ready = 1; rsp_b_ready = 1;
    repeat (6) @(posedge clk);
    #1 rsp_a_ready = 0; rsp_b_ready = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 0;
    req_a_valid = 0; req_a_in1 = '0; req_a_in2 = '0; req_a_sel = '0; rsp_a_ready = 0;
    req_b_valid = 0; req_b_in1 = '0; req_b_in2 = '0; req_b_sel = '0; rsp_b_ready = 0;
    test_reset();
    test_a_only();
    test_contention();
    test_back_to_back();
    test_backpressure();
    test_undefined_op();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 32-bit combinational ALU between two requesters, port A and port B (for example, the core datapath and an address/branch helper unit).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers the operands into the ALU, captures result/zero and returns them to the winning requester.
- It sits between the requesters and the alu instance; it owns the ALU's in1/in2/sel inputs.

Parameters:
- DATA_W, 32, operand/result width (must match ALU)
- SEL_W, 4, ALU op-select width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req_a_valid  input  1  A request valid
- req_a_ready  output  1  A request accepted this cycle
- req_a_in1  input  DATA_W  A operand 1
- req_a_in2  input  DATA_W  A operand 2
- req_a_sel  input  SEL_W  A op select
- rsp_a_valid  output  1  A response valid
- rsp_a_ready  input  1  A response consumed
- rsp_a_result  output  DATA_W  A result
- rsp_a_zero  output  1  A zero flag
- req_b_* / rsp_b_*  same set, same widths, for requester B
- alu_in1  output  DATA_W  to ALU in1
- alu_in2  output  DATA_W  to ALU in2
- alu_sel  output  SEL_W  to ALU sel
- alu_result  input  DATA_W  from ALU result
- alu_zero  input  1  from ALU zero

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low. While rst_n=0:
  - state=IDLE, last_grant=B;
  - alu_in1/alu_in2/alu_sel regs=0;
  - captured result=0, zero=0, owner=A;
  - all *_ready and *_valid outputs=0 (readies gated by rst_n).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester. If both are valid, the one not equal to last_grant.
  - req_X_ready=1 combinationally for the granted requester only, and only in IDLE. The other ready is 0.
  - On handshake (valid&ready): latch in1/in2/sel into the alu_* regs, owner<=X, go to EXEC.
  - No valid: stay in IDLE.
- EXEC: alu_* regs are stable for one full cycle. At the rising edge, capture alu_result/alu_zero into the response regs, then go to RESP.
- RESP:
  - rsp_owner_valid=1, with result/zero held stable. The other rsp valid is 0.
  - On rsp_ready=1: go to IDLE and set last_grant<=owner.
  - No request is accepted in EXEC or RESP; both req readies are 0.
- Latency: handshake edge N → rsp valid visible from cycle N+2. Minimum spacing between accepts is 3 cycles.
- Response timing: rsp_ready may already be high when rsp_valid rises, giving a 1-cycle RESP.
- alu_* outputs hold their last operands after an op completes. They are not cleared.
- Requester rules: a requester must hold valid and its operands stable until ready. Dropping valid before ready is legal; no grant is reserved for it.
- Undefined sel codes (6..15) are passed through unchanged. The ALU yields result=0, zero=1, which is returned as-is with no error flag.
- rst_n low in EXEC or RESP: the operation is aborted, the response is never delivered, and the block returns to the reset state next edge.
- Simultaneous valid on both ports at reset exit: A wins, because last_grant=B.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5.
  - FSM state encoding (IDLE/EXEC/RESP).
  - Requester id encoding (A=0, B=1).
- One sub-module, rr_arb2:
  - inputs: two requests and last_grant;
  - output: one-hot grant;
  - purely combinational.
- The FSM, operand registers and response registers stay in alu_share_arb.

Test Plan:
- Reset, then A only: A req in1=5, in2=7, sel=0. Expect req_a_ready=1 in the same cycle, alu_in1=5/alu_in2=7 next cycle, rsp_a_valid at +2 with result=12, zero=0. rsp_b_valid stays 0 throughout.
- Both valid from reset: A sel=1 (10-10), B sel=2 (0xF0&0x0F). Expect A first, result=0/zero=1. Then B, result=0/zero=1. Then, with both still valid, A again.
- Back-to-back B only: three requests with sel=3 (1|2), sel=4 (6^3), sel=5 (-1 vs 1). Expect results 3, 5, 1, each 3 cycles apart with rsp_b_ready tied to 1.
- Response backpressure: hold rsp_a_ready=0 for 5 cycles. Expect rsp_a_valid and result held stable, B's valid request not accepted. After ready=1, B is accepted in the next IDLE cycle.
- Undefined op: sel=9, in1=3, in2=4. Expect result=0, zero=1, delivered normally.
- Reset mid-op: assert rst_n=0 during EXEC. Expect no rsp_valid, all outputs 0. After release, a new A/B contention grants A.
